// File: rtl/inst_encoder.sv
// inst_encoder: packs RISC-V style instruction fields into 32-bit words and
// streams them, with consecutive word addresses, to an instruction-memory writer.
// A single output register provides a valid/ready handshake on each side.
// Optional build macro STRICT_RANGE_EN: reject immediates that the selected
// format cannot represent exactly (emits NOP with out_err=1).
module inst_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_count
);

    localparam logic [0:0]        ST_EMPTY = 1'b0;
    localparam logic [0:0]        ST_FULL  = 1'b1;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       NOP      = 32'h0000_0013;

    logic [0:0]        state_q, state_d;
    logic [31:0]       inst_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [7:0]        errcnt_q, errcnt_d;

    logic        accept, out_hs;
    logic [31:0] packed_inst;
    logic        fmt_bad;
    logic        enc_err;
    logic [31:0] enc_inst;

    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    assign out_inst  = inst_q;
    assign out_err   = err_q;
    assign out_addr  = addr_q;
    assign err_count = errcnt_q;

    // Field packing per instruction format; illegal formats flagged.
    always_comb begin
        packed_inst = NOP;
        fmt_bad     = 1'b0;
        case (fmt)
            3'd0: packed_inst = {funct7, rs2, rs1, funct3, rd, opcode};
            3'd1: packed_inst = {imm[11:0], rs1, funct3, rd, opcode};
            3'd2: packed_inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            3'd3: packed_inst = {imm[12], imm[10:5], rs2, rs1, funct3,
                                 imm[4:1], imm[11], opcode};
            3'd4: packed_inst = {imm[31:12], rd, opcode};
            3'd5: packed_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: fmt_bad = 1'b1;
        endcase
    end

`ifdef STRICT_RANGE_EN
    logic range_bad;

    // Immediate must be exactly representable in the selected format.
    always_comb begin
        range_bad = 1'b0;
        case (fmt)
            3'd1, 3'd2: range_bad = !((&imm[31:11]) || !(|imm[31:11]));
            3'd3:       range_bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            3'd4:       range_bad = |imm[11:0];
            3'd5:       range_bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            default:    range_bad = 1'b0;
        endcase
    end

    assign enc_err = fmt_bad || range_bad;
`else
    logic unused_imm0;
    assign unused_imm0 = imm[0];
    assign enc_err     = fmt_bad;
`endif

    assign enc_inst = enc_err ? NOP : packed_inst;

    // Next-state logic: FSM, address counter and saturating error counter.
    // The counter advances on output handshakes, so a word loaded in the same
    // cycle as a handshake takes the post-increment (or post-clear) value.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept)            state_d = ST_FULL;
            ST_FULL:  if (out_hs && !accept) state_d = ST_EMPTY;
            default:                         state_d = ST_EMPTY;
        endcase

        cnt_d = cnt_q;
        if (clear)       cnt_d = BASE;
        else if (out_hs) cnt_d = cnt_q + 1'b1;

        errcnt_d = errcnt_q;
        if (clear)                                         errcnt_d = '0;
        else if (accept && enc_err && errcnt_q != 8'hFF)   errcnt_d = errcnt_q + 8'd1;
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            cnt_q    <= BASE;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            errcnt_q <= errcnt_d;
        end
    end

    // Output word register, loaded on each accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q <= '0;
            err_q  <= 1'b0;
            addr_q <= BASE;
        end else if (accept) begin
            inst_q <= enc_inst;
            err_q  <= enc_err;
            addr_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed testbench for inst_encoder: table of encoding vectors plus
// hand-written sequences for stall, address wrap, clear, saturation and reset.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready, in_ready2;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid, out_valid2;
    logic        out_ready;
    logic [31:0] out_inst, out_inst2;
    logic [9:0]  out_addr;
    logic [1:0]  out_addr2;
    logic        out_err, out_err2;
    logic [7:0]  err_count, err_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err),
        .err_count(err_count)
    );

    inst_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready2),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_inst(out_inst2), .out_addr(out_addr2), .out_err(out_err2),
        .err_count(err_count2)
    );

    typedef struct {
        logic [2:0]  f;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];
    vec_t sreq[4];

    function automatic vec_t mk(input logic [2:0] f, input logic [6:0] op,
                                input logic [4:0] a_rd, input logic [4:0] a_rs1,
                                input logic [4:0] a_rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] im,
                                input logic [31:0] ei, input logic ee);
        vec_t v;
        v.f = f; v.op = op; v.rd = a_rd; v.rs1 = a_rs1; v.rs2 = a_rs2;
        v.f3 = f3; v.f7 = f7; v.imm = im; v.exp_inst = ei; v.exp_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        fmt = v.f; opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        funct3 = v.f3; funct7 = v.f7; imm = v.imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ec;
        int idx, got, acc_n;
        logic acc, hs;
        logic [31:0] g_inst[16];
        logic [9:0]  g_addr[16];
        logic [1:0]  g_addr2[16];
        vec_t bad;
        vec_t leg;

        vecs[0]  = mk(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF10093, 1'b0);
        vecs[1]  = mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE208EE3, 1'b0);
        vecs[2]  = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,      32'h001000EF, 1'b0);
        vecs[3]  = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h123452B7, 1'b0);
        vecs[4]  = mk(3'd0, 7'h33, 5'd5, 5'd6, 5'd7, 3'd0, 7'h20, 32'h0,         32'h407302B3, 1'b0);
        vecs[5]  = mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,         32'h0020A423, 1'b0);
        vecs[6]  = mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'hFFFF_FFF8, 32'hFE20AC23, 1'b0);
        vecs[7]  = mk(3'd6, 7'h33, 5'd5, 5'd6, 5'd7, 3'd0, 7'h20, 32'h0,         32'h00000013, 1'b1);
        vecs[8]  = mk(3'd7, 7'h13, 5'd1, 5'd2, 5'd3, 3'd1, 7'h7F, 32'hFFFF_FFFF, 32'h00000013, 1'b1);
`ifdef STRICT_RANGE_EN
        vecs[9]  = mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd4097,      32'h00000013, 1'b1);
        vecs[10] = mk(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'd2048,      32'h00000013, 1'b1);
        vecs[11] = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5001, 32'h00000013, 1'b1);
        vecs[12] = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3,         32'h00000013, 1'b1);
        bad      = mk(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'd4096,      32'h00000013, 1'b1);
`else
        vecs[9]  = mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd4097,      32'h80208063, 1'b0);
        vecs[10] = mk(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'd2048,      32'h80010093, 1'b0);
        vecs[11] = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5001, 32'h123452B7, 1'b0);
        vecs[12] = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3,         32'h002000EF, 1'b0);
        bad      = mk(3'd7, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'd0,         32'h00000013, 1'b1);
`endif
        vecs[13] = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFE, 32'hFFFFF0EF, 1'b0);

        sreq[0] = mk(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'd0, 32'h00010093, 1'b0);
        sreq[1] = mk(3'd1, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 7'h00, 32'd1, 32'h00110113, 1'b0);
        sreq[2] = mk(3'd1, 7'h13, 5'd3, 5'd2, 5'd0, 3'd0, 7'h00, 32'd2, 32'h00210193, 1'b0);
        sreq[3] = mk(3'd1, 7'h13, 5'd4, 5'd2, 5'd0, 3'd0, 7'h00, 32'd3, 32'h00310213, 1'b0);
        leg = sreq[0];

        // ---------------- reset state ----------------
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(leg);
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // ---------------- encoding table ----------------
        exp_ec = 0;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            in_valid = 1'b1; out_ready = 1'b1;
            #1;
            chk($sformatf("tab%0d_in_ready", i), in_ready, 1);
            tick();
            in_valid = 1'b0; out_ready = 1'b0;
            if (vecs[i].exp_err && exp_ec < 255) exp_ec++;
            chk($sformatf("tab%0d_valid", i), out_valid, 1);
            chk($sformatf("tab%0d_inst", i), out_inst, vecs[i].exp_inst);
            chk($sformatf("tab%0d_err", i), out_err, vecs[i].exp_err);
            chk($sformatf("tab%0d_addr", i), out_addr, i);
            chk($sformatf("tab%0d_err_count", i), err_count, exp_ec);
            tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk($sformatf("tab%0d_drained", i), out_valid, 0);
        end

        // ---------------- back-to-back with 3-cycle stall ----------------
        do_reset();
        idx = 0; got = 0;
        for (int c = 0; c < 12; c++) begin
            if (idx < 4) begin drive(sreq[idx]); in_valid = 1'b1; end
            else in_valid = 1'b0;
            out_ready = (c >= 1 && c <= 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (c >= 1 && c <= 3) begin
                chk("stall_in_ready", in_ready, 0);
                chk("stall_valid", out_valid, 1);
                chk("stall_inst_hold", out_inst, 32'h00010093);
                chk("stall_addr_hold", out_addr, 0);
            end
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            if (hs) begin
                if (got < 16) begin g_inst[got] = out_inst; g_addr[got] = out_addr; end
                got++;
            end
            if (acc) idx++;
            tick();
        end
        chk("stall_word_count", got, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < got) begin
                chk($sformatf("stall_addr%0d", k), g_addr[k], k);
                chk($sformatf("stall_inst%0d", k), g_inst[k], sreq[k].exp_inst);
            end
        end

        // ---------------- ADDR_W=2 wrap, then clear with handshake ----------------
        do_reset();
        idx = 0; got = 0;
        for (int c = 0; c < 12; c++) begin
            if (idx < 5) begin
                drive(leg);
                if (idx == 2) fmt = 3'd6;
                in_valid = 1'b1;
            end else in_valid = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            acc = in_valid && in_ready;
            hs  = out_valid2 && out_ready;
            if (hs) begin
                if (got < 16) g_addr2[got] = out_addr2;
                got++;
            end
            if (acc) idx++;
            tick();
        end
        chk("wrap_word_count", got, 5);
        for (int k = 0; k < 5; k++) begin
            if (k < got) chk($sformatf("wrap_addr%0d", k), g_addr2[k], k % 4);
        end
        chk("wrap_err_count", err_count2, 1);
        drive(leg); in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("held_addr_w2", out_addr2, 1);
        chk("held_addr_w10", out_addr, 5);
        clear = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("clear_hs_valid", out_valid2, 1);
        tick();
        clear = 1'b0;
        chk("clear_err_count_w2", err_count2, 0);
        chk("clear_err_count_w10", err_count, 0);
        chk("clear_drained", out_valid2, 0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("after_clear_addr_w2", out_addr2, 0);
        chk("after_clear_addr_w10", out_addr, 0);
        tick();

        // ---------------- error counter saturation ----------------
        do_reset();
        drive(bad); in_valid = 1'b1; out_ready = 1'b1;
        acc_n = 0;
        for (int c = 0; c < 400 && acc_n < 300; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) acc_n++;
            if (acc_n == 255) chk("sat_at_255_pending", err_count, 254);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("sat_accepted", acc_n, 300);
        chk("sat_err_count", err_count, 255);
        chk("sat_last_err", out_err, 1);

        // ---------------- reset while FULL ----------------
        drive(leg); in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("full_before_reset", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_out_inst", out_inst, 0);
        chk("mrst_out_err", out_err, 0);
        chk("mrst_out_addr", out_addr, 0);
        chk("mrst_err_count", err_count, 0);
        chk("mrst_in_ready", in_ready, 1);
        in_valid = 1'b1;
        tick();
        chk("mrst_no_accept", out_valid, 0);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("post_rst_no_dup", out_valid, 0);
        drive(sreq[1]); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post_rst_inst", out_inst, 32'h00110113);
        chk("post_rst_addr", out_addr, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: width of the instruction-memory word address.
REQ-002 SHALL have parameter BASE_ADDR, default 0: address assigned to the first emitted word.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port clear, input, 1: synchronous restart of the address and error counters.
REQ-006 SHALL have port in_valid, input, 1: request fields are valid.
REQ-007 SHALL have port in_ready, output, 1: block accepts a request this cycle.
REQ-008 SHALL have port fmt, input, 3: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
REQ-009 SHALL have ports opcode (7), rd (5), rs1 (5), rs2 (5), funct3 (3) and funct7 (7), all inputs: instruction fields.
REQ-010 SHALL have port imm, input, 32: immediate value as a full signed integer.
REQ-011 SHALL have port out_valid, output, 1: out_inst, out_addr and out_err are valid.
REQ-012 SHALL have port out_ready, input, 1: downstream (instruction-memory writer) accepts the word.
REQ-013 SHALL have port out_inst, output, 32: encoded instruction word.
REQ-014 SHALL have port out_addr, output, ADDR_W: word address of out_inst.
REQ-015 SHALL have port out_err, output, 1: the request could not be encoded faithfully.
REQ-016 SHALL have port err_count, output, 8: count of erroneous requests accepted.

Function
REQ-017 Input handshake: a request is accepted when in_valid && in_ready; in_ready = !out_valid || out_ready (one output register, no bubble under continuous flow).
REQ-018 Latency: accepted request appears on out_* the next cycle; out_* SHALL hold stable while out_valid && !out_ready.
REQ-019 FSM with states EMPTY and FULL. EMPTY->FULL on accept. FULL->EMPTY on output handshake with no accept. FULL->FULL on output handshake with a simultaneous accept, or on stall.
REQ-020 Every format SHALL place inst[6:0]=opcode.
REQ-021 R format: funct7 | rs2 | rs1 | funct3 | rd.
REQ-022 I format: imm[11:0] | rs1 | funct3 | rd.
REQ-023 S format: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0].
REQ-024 B format: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11].
REQ-025 U format: imm[31:12] | rd.
REQ-026 J format: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd.
REQ-027 out_addr SHALL start at BASE_ADDR and increment by 1 on each output handshake, wrapping modulo 2^ADDR_W with no flag.
REQ-028 clear SHALL set the next-address counter to BASE_ADDR and err_count to 0. A word held in the output register keeps its already-assigned out_addr. clear has priority over a simultaneous increment.
REQ-029 err_count SHALL increment on acceptance of any request later flagged out_err, and SHALL saturate at 255.
REQ-030 An illegal fmt (6 or 7) SHALL always produce out_err=1 and out_inst=32'h00000013 (NOP).

Reset
REQ-031 While rst_n=0, the block SHALL hold: state EMPTY, out_valid=0, out_inst=0, out_err=0, out_addr=BASE_ADDR, next address=BASE_ADDR, err_count=0, in_ready=1.
REQ-032 Reset asserted mid-transfer SHALL discard the held word; no partial or duplicate emission after release.

Configuration
REQ-033 Macro STRICT_RANGE_EN defined: out_err=1 and out_inst=32'h00000013 whenever any of the following holds:
- I or S format and imm is not the sign-extension of imm[11:0];
- B format and imm is not the sign-extension of imm[12:0], or imm[0]=1;
- J format and imm is not the sign-extension of imm[20:0], or imm[0]=1;
- U format and imm[11:0]!=0.
REQ-034 Macro STRICT_RANGE_EN undefined: the fields listed in REQ-021 to REQ-026 are packed unchecked, and out_err is set only for illegal fmt.

Verification
REQ-035 I format, opcode=7'b0010011, rd=1, rs1=2, funct3=0, imm=-1 -> out_inst=32'hFFF10093, out_err=0, out_addr=BASE_ADDR.
REQ-036 B format, opcode=7'b1100011, rs1=1, rs2=2, funct3=0, imm=-4 -> out_inst=32'hFE208EE3. With STRICT_RANGE_EN and imm=4097 -> out_inst=32'h00000013, out_err=1, err_count=1.
REQ-037 J format, opcode=7'b1101111, rd=1, imm=2048 -> out_inst=32'h001000EF. U format, imm=32'h12345000, rd=5, opcode=7'b0110111 -> out_inst=32'h123452B7.
REQ-038 Back-to-back 4 requests with out_ready held 0 for 3 cycles -> first word stable, in_ready=0 during the stall, out_addr sequence 0,1,2,3, no loss or duplication.
REQ-039 ADDR_W=2, 5 words -> out_addr 0,1,2,3,0. Then clear asserted together with an output handshake -> next word at BASE_ADDR, err_count=0.
REQ-040 300 out-of-range requests with STRICT_RANGE_EN -> err_count=255. rst_n pulsed low while FULL -> out_valid=0 immediately and all REQ-031 values restored.
